// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register (D/E/M/W).
// The stage holds on a stall, flushes to a NOP on a bubble and advances otherwise.
// A bubble wins over a stall, so a taken jump can flush a stalled stage.
// It also keeps saturating stall and bubble statistics and a sticky stall watchdog for debug.
module pipe_stage_reg #(
  parameter int unsigned DATA_W    = 64,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr_stat_i,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              stall_timeout
);

  // Run counter must be able to hold MAX_STALL itself (saturation point).
  localparam int unsigned      RUN_W   = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } mode_e;

  // Qualified per-cycle controls
  logic stall_only;
  logic advance;

  // Datapath registers
  logic              valid_q, valid_d;
  logic [31:0]       pc_q,    pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Stage mode and watchdog state
  mode_e             mode_q,    mode_d;
  logic [RUN_W-1:0]  run_q,     run_d;
  logic              timeout_q, timeout_d;

  // Statistics
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  assign stall_only = stall_i & ~bubble_i;
  assign advance    = ~stall_i & ~bubble_i;

  // Next contents of the stage: flush, hold or load from upstream
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    data_d  = data_q;
    if (bubble_i) begin
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = NOP_INSTR;
      data_d  = '0;
    end else if (advance) begin
      valid_d = in_valid;
      pc_d    = in_pc;
      instr_d = in_instr;
      data_d  = in_data;
    end
  end

  // Stage content registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      data_q  <= data_d;
    end
  end

  // Mode: only a stall-only cycle keeps or enters HOLD
  always_comb begin
    mode_d = RUN;
    if (stall_only) begin
      mode_d = HOLD;
    end
  end

  // Consecutive stall-only cycle count, saturating at MAX_STALL
  always_comb begin
    run_d = run_q;
    if (clr_stat_i) begin
      run_d = '0;
    end else if (stall_only) begin
      if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_W'(1);
      end
    end else if (mode_q == HOLD) begin
      run_d = '0;
    end
  end

  // Sticky watchdog: set once the run count reaches MAX_STALL
  always_comb begin
    timeout_d = timeout_q;
    if (clr_stat_i) begin
      timeout_d = 1'b0;
    end else if (run_d == RUN_MAX) begin
      timeout_d = 1'b1;
    end
  end

  // Saturating statistic counters; clear wins over increment
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (clr_stat_i) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall_only && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (bubble_i && (bubble_cnt_q != '1)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  // Mode, watchdog and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= RUN;
      run_q        <= '0;
      timeout_q    <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      mode_q       <= mode_d;
      run_q        <= run_d;
      timeout_q    <= timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_instr     = instr_q;
  assign out_data      = data_q;
  assign stall_cnt     = stall_cnt_q;
  assign bubble_cnt    = bubble_cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with CNT_W=2 and MAX_STALL=4.
// Expected values are hand-computed constants.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        bubble_i;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [63:0] in_data;
  logic        clr_stat_i;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [63:0] out_data;
  logic [1:0]  stall_cnt;
  logic [1:0]  bubble_cnt;
  logic        stall_timeout;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(
    .DATA_W   (64),
    .NOP_INSTR(32'h00000013),
    .CNT_W    (2),
    .MAX_STALL(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .bubble_i     (bubble_i),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .in_data      (in_data),
    .clr_stat_i   (clr_stat_i),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_data     (out_data),
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt),
    .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge; returns 1 time unit after it, away from the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = {pc[15:0], 16'h0093};
    in_data  = {32'hA5A5_0000, pc};
  endtask

  initial begin
    rst_n = 1'b1; stall_i = 1'b0; bubble_i = 1'b0; clr_stat_i = 1'b0;
    drive(1'b0, 32'h0);

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_pc", {32'd0, out_pc}, 64'd0);
    chk("rst_instr", {32'd0, out_instr}, 64'h13);
    chk("rst_data", out_data, 64'd0);
    chk("rst_scnt", {62'd0, stall_cnt}, 64'd0);
    chk("rst_bcnt", {62'd0, bubble_cnt}, 64'd0);
    chk("rst_tmo", {63'd0, stall_timeout}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Flow: one-cycle latency
    drive(1'b1, 32'h100);
    #1 chk("flow_nocomb", {32'd0, out_pc}, 64'd0);
    cyc(); chk("flow_pc0", {32'd0, out_pc}, 64'h100);
    chk("flow_valid0", {63'd0, out_valid}, 64'd1);
    chk("flow_instr0", {32'd0, out_instr}, 64'h0100_0093);
    chk("flow_data0", out_data, 64'hA5A5_0000_0000_0100);
    drive(1'b1, 32'h104); cyc(); chk("flow_pc1", {32'd0, out_pc}, 64'h104);
    drive(1'b1, 32'h108); cyc(); chk("flow_pc2", {32'd0, out_pc}, 64'h108);
    drive(1'b1, 32'h10C); cyc(); chk("flow_pc3", {32'd0, out_pc}, 64'h10C);

    // Stall: three stall-only cycles hold the stage
    drive(1'b1, 32'h200); stall_i = 1'b1;
    cyc(); chk("stall1_pc", {32'd0, out_pc}, 64'h10C);
    chk("stall1_cnt", {62'd0, stall_cnt}, 64'd1);
    cyc(); cyc();
    chk("stall3_pc", {32'd0, out_pc}, 64'h10C);
    chk("stall3_data", out_data, 64'hA5A5_0000_0000_010C);
    chk("stall3_cnt", {62'd0, stall_cnt}, 64'd3);
    chk("stall3_tmo", {63'd0, stall_timeout}, 64'd0);
    stall_i = 1'b0;
    cyc(); chk("release_pc", {32'd0, out_pc}, 64'h200);
    chk("release_tmo", {63'd0, stall_timeout}, 64'd0);

    // Clear statistics; stage still advances
    clr_stat_i = 1'b1; drive(1'b1, 32'h204);
    cyc(); clr_stat_i = 1'b0;
    chk("clr_scnt", {62'd0, stall_cnt}, 64'd0);
    chk("clr_pc", {32'd0, out_pc}, 64'h204);

    // Stall and bubble together: bubble wins
    stall_i = 1'b1; bubble_i = 1'b1; drive(1'b1, 32'h208);
    cyc();
    chk("sb_valid", {63'd0, out_valid}, 64'd0);
    chk("sb_instr", {32'd0, out_instr}, 64'h13);
    chk("sb_pc", {32'd0, out_pc}, 64'd0);
    chk("sb_data", out_data, 64'd0);
    chk("sb_bcnt", {62'd0, bubble_cnt}, 64'd1);
    chk("sb_scnt", {62'd0, stall_cnt}, 64'd0);
    bubble_i = 1'b0;

    // Watchdog: four consecutive stall-only cycles
    cyc(); cyc(); cyc();
    chk("wd3_tmo", {63'd0, stall_timeout}, 64'd0);
    chk("wd3_instr", {32'd0, out_instr}, 64'h13);
    cyc();
    chk("wd4_tmo", {63'd0, stall_timeout}, 64'd1);
    chk("wd4_scnt_sat", {62'd0, stall_cnt}, 64'd3);
    stall_i = 1'b0; drive(1'b1, 32'h300);
    cyc();
    chk("wd_rel_tmo", {63'd0, stall_timeout}, 64'd1);
    chk("wd_rel_pc", {32'd0, out_pc}, 64'h300);

    // Clear during a stall clears the run count too
    stall_i = 1'b1; clr_stat_i = 1'b1; drive(1'b1, 32'h304);
    cyc(); clr_stat_i = 1'b0;
    chk("clrst_tmo", {63'd0, stall_timeout}, 64'd0);
    chk("clrst_scnt", {62'd0, stall_cnt}, 64'd0);
    chk("clrst_bcnt", {62'd0, bubble_cnt}, 64'd0);
    chk("clrst_pc", {32'd0, out_pc}, 64'h300);
    cyc(); cyc(); cyc();
    chk("clrst3_tmo", {63'd0, stall_timeout}, 64'd0);
    cyc();
    chk("clrst4_tmo", {63'd0, stall_timeout}, 64'd1);
    stall_i = 1'b0;

    // Bubble counter saturation
    clr_stat_i = 1'b1; cyc(); clr_stat_i = 1'b0;
    chk("clr2_tmo", {63'd0, stall_timeout}, 64'd0);
    bubble_i = 1'b1;
    cyc(); chk("bub1", {62'd0, bubble_cnt}, 64'd1);
    cyc(); chk("bub2", {62'd0, bubble_cnt}, 64'd2);
    cyc(); chk("bub3", {62'd0, bubble_cnt}, 64'd3);
    cyc(); cyc(); cyc();
    chk("bub6_sat", {62'd0, bubble_cnt}, 64'd3);
    chk("bub6_valid", {63'd0, out_valid}, 64'd0);
    bubble_i = 1'b0;

    // Reset in the middle of a stall
    drive(1'b1, 32'h400);
    cyc(); chk("pre_rst_pc", {32'd0, out_pc}, 64'h400);
    stall_i = 1'b1;
    cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_pc", {32'd0, out_pc}, 64'd0);
    chk("mrst_instr", {32'd0, out_instr}, 64'h13);
    chk("mrst_scnt", {62'd0, stall_cnt}, 64'd0);
    chk("mrst_bcnt", {62'd0, bubble_cnt}, 64'd0);
    #2 rst_n = 1'b1;
    stall_i = 1'b0; drive(1'b1, 32'h500);
    cyc();
    chk("post_rst_pc", {32'd0, out_pc}, 64'h500);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    // Two pre-reset stalls must not count toward the watchdog
    stall_i = 1'b1;
    cyc(); cyc(); cyc();
    chk("post_rst_tmo", {63'd0, stall_timeout}, 64'd0);
    chk("post_rst_scnt", {62'd0, stall_cnt}, 64'd3);
    stall_i = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
